adder_seq32: RTL
================

# adder_seq32

Multi-cycle sequencer that performs an NBYTES-wide addition, 32 bits by default, using a single `adder_8bit` instance. The block processes one byte per clock, least-significant byte first, and carries between bytes through an internal carry register. It sits between a requester that issues `start` and the shared 8-bit adder datapath, and reports `busy`/`done` along with the registered result.

## Interface
- `NBYTES`, default 4: number of byte slices; legal range 2..8; operand/result width W = 8*NBYTES.
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when the block is idle-capable (IDLE or DONE).
- `a` input W: operand A; captured on start acceptance.
- `b` input W: operand B; captured on start acceptance.
- `ci` input 1: carry-in to byte 0; captured on start acceptance.
- `busy` output 1: high while bytes are being added (state ADD).
- `done` output 1: single-cycle pulse; result valid.
- `sum` output W: registered result; holds until next accepted start.
- `co` output 1: registered carry-out of the top byte; holds with `sum`.

## Operation
- One `adder_8bit` instance. Its inputs are `a_reg[8*idx+:8]`, `b_reg[8*idx+:8]` and `c_reg`. Its outputs are written into `sum[8*idx+:8]` and `c_reg`.
- Registers:
  - `a_reg` and `b_reg` (W each)
  - `c_reg` (1)
  - `idx` (3 bits)
  - state (2 bits)
  - `sum` (W)
  - `co` (1)
- **IDLE**, on `start`=1:
  - Capture `a`, `b` and `ci` (into `c_reg`).
  - Set `idx`=0 and clear `sum` and `co` to 0.
  - Go to ADD.
- **ADD**, each cycle:
  - Write result byte `idx` and update `c_reg`.
  - If `idx`=NBYTES-1: set `co` to the adder carry-out and go to DONE.
  - Otherwise: increment `idx`.
- **DONE**, one cycle:
  - `done`=1, `busy`=0.
  - If `start`=1, accept exactly as in IDLE and go to ADD (back-to-back).
  - Otherwise go to IDLE.
- `start` while in ADD is ignored. It has no effect on operands, `idx` or outputs, and is not queued.
- Operand inputs `a`, `b` and `ci` may change freely after acceptance. Only the captured copies are used.
- Arithmetic is unsigned modulo 2^W, with carry-out in `co`. The result is identical to a W-bit ripple add of `a + b + ci`.
- Outputs are decoded from state:
  - `busy` = (state==ADD)
  - `done` = (state==DONE)
- No other states exist. An unreachable encoding returns to IDLE on the next edge.

## Timing
- Reset (`rst`=1 at an edge), regardless of state:
  - state=IDLE, `idx`=0, `c_reg`=0.
  - `a_reg`/`b_reg`=0, `sum`=0, `co`=0.
  - `busy`=0, `done`=0.
- Reset mid-operation aborts the operation. No `done` pulse is produced and the partial sum is discarded.
- Reset takes priority over `start` in the same cycle.
- Latency for start sampled at edge E0:
  - `busy` is high in the cycles following edges E0..E0+NBYTES-1.
  - Byte k is committed at edge E0+1+k.
  - `done` is high for exactly one cycle after edge E0+NBYTES. For NBYTES=4, `done` goes high 4 edges after E0.
- `sum`/`co` are final and stable from the `done` cycle until the edge that accepts the next start.
- During ADD, `sum` shows partially written bytes. Bytes not yet written read 0. The consumer uses `sum` only on or after `done`.
- Back-to-back: `start` held high continuously yields one operation per NBYTES+1 cycles (4 busy cycles + 1 done cycle at default).
- Throughput bound: no operation is accepted while `busy`=1.

## Test plan
- **Reset state:** assert `rst` 2 cycles with random inputs -> `busy`=0, `done`=0, `sum`=0, `co`=0. Release with `start`=0 -> outputs stay 0 indefinitely.
- **Full carry ripple:** `a`=0xFFFFFFFF, `b`=0x00000001, `ci`=0, pulse `start` -> `busy` high for 4 cycles, then `done` for 1 cycle with `sum`=0x00000000, `co`=1. Values hold until the next start.
- **Carry-in and no overflow:** `a`=0x12345678, `b`=0x11111111, `ci`=1 -> `sum`=0x2345678A, `co`=0. Change `a`/`b` to 0 one cycle after start -> result unchanged.
- **Start ignored while busy:** start `a`=0x80000000, `b`=0x80000000, `ci`=0, then pulse `start` with `a`=`b`=0x1 two cycles later -> a single `done` with `sum`=0x00000000, `co`=1. No second operation follows.
- **Back-to-back:** hold `start`=1 with `a`=0x000000FF, `b`=0x00000001, `ci`=0 -> `done` every 5 cycles, each time with `sum`=0x00000100, `co`=0. `busy` is low only in the `done` cycles.
- **Reset mid-operation:** start `a`=0xFFFFFFFF, `b`=0xFFFFFFFF, `ci`=1, then assert `rst` after 2 busy cycles -> the next cycle shows `busy`=0, `done`=0, `sum`=0, `co`=0. No `done` pulse ever appears for the aborted operation. A subsequent start with 1+1 gives `sum`=0x00000002.

Source files
------------

// File: rtl/adder_seq32.sv
// Byte-serial NBYTES-wide adder: one shared 8-bit adder, least-significant byte first,
// with the inter-byte carry held in c_reg between cycles.

module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [8:0] total;

  always_comb total = {1'b0, a} + {1'b0, b} + {8'd0, ci};

  assign s  = total[7:0];
  assign co = total[8];
endmodule

module adder_seq32 #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                ci,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                co
);
  localparam int W = 8 * NBYTES;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] IDX_LAST = 3'(NBYTES - 1);

  logic [1:0]   state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [W-1:0] a_reg_q, a_reg_d;
  logic [W-1:0] b_reg_q, b_reg_d;
  logic         c_reg_q, c_reg_d;
  logic [W-1:0] sum_q, sum_d;
  logic         co_q, co_d;

  logic         in_add;
  logic         accept;
  logic         last_byte;
  logic [7:0]   op_a, op_b;
  logic [7:0]   byte_s;
  logic         byte_co;

  // Byte lanes padded to 8 entries so the 3-bit idx always selects a defined lane.
  logic [7:0]   a_byte [8];
  logic [7:0]   b_byte [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    if (gi < NBYTES) begin : g_used
      assign a_byte[gi] = a_reg_q[8*gi +: 8];
      assign b_byte[gi] = b_reg_q[8*gi +: 8];
    end else begin : g_unused
      assign a_byte[gi] = 8'h00;
      assign b_byte[gi] = 8'h00;
    end
  end

  assign op_a = a_byte[idx_q];
  assign op_b = b_byte[idx_q];

  adder_8bit u_adder (
    .a  (op_a),
    .b  (op_b),
    .ci (c_reg_q),
    .s  (byte_s),
    .co (byte_co)
  );

  assign in_add    = (state_q == ST_ADD);
  assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_byte = (idx_q == IDX_LAST);

  // Each result byte is cleared on acceptance and written only in its own ADD cycle.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_sum
    assign sum_d[8*gi +: 8] = accept                         ? 8'h00  :
                              (in_add && idx_q == 3'(gi))    ? byte_s :
                                                               sum_q[8*gi +: 8];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    c_reg_d = c_reg_q;
    co_d    = co_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          a_reg_d = a;
          b_reg_d = b;
          c_reg_d = ci;
          idx_d   = 3'd0;
          co_d    = 1'b0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        c_reg_d = byte_co;
        if (last_byte) begin
          co_d    = byte_co;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      a_reg_q <= '0;
      b_reg_q <= '0;
      c_reg_q <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
      c_reg_q <= c_reg_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign busy = in_add;
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign co   = co_q;
endmodule
